// File: rtl/dsp_sample_loader_pkg.sv
// Shared definitions for the DSP sample loader: half and writer state encodings
// plus the helper that maps a ping-pong half onto its bank I base address.
package dsp_sample_loader_pkg;

    typedef enum logic [1:0] {
        HALF_EMPTY   = 2'd0,
        HALF_FILLING = 2'd1,
        HALF_FULL    = 2'd2
    } half_state_t;

    typedef enum logic {
        W_FILL  = 1'b0,
        W_STALL = 1'b1
    } writer_state_t;

    localparam logic HALF_0 = 1'b0;
    localparam logic HALF_1 = 1'b1;

    localparam int DROP_COUNT_W = 16;

    // Half 1 starts at the midpoint of the bank; half 0 at address zero.
    function automatic logic [31:0] half_base(input logic half, input int addr_w);
        return 32'(half) << (addr_w - 1);
    endfunction

endpackage

// File: rtl/dsp_loader_half_tracker.sv
// Ownership tracker for the two bank I halves: per-half state, oldest-full
// ordering and the registered frame_ready / frame_base presentation.
module dsp_loader_half_tracker
    import dsp_sample_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_start,
    input  logic              fill_complete,
    input  logic              fill_half,
    input  logic              frame_done,
    output logic [1:0]        half_empty,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] frame_base,
    output logic              release_valid,
    output logic              release_half
);

    logic [1:0] half_full;
    logic       ready_reg;
    logic       pres_half_reg;
    logic       older_reg;
    logic       sel_half;

    assign release_valid = ready_reg & frame_done;
    assign release_half  = pres_half_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_half
            localparam logic THIS_HALF = 1'(gi);
            half_state_t state_reg;

            // A release and a completion never target the same half, so the
            // priority order below only matters for robustness.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= HALF_EMPTY;
                end else if (release_valid && (release_half == THIS_HALF)) begin
                    state_reg <= HALF_EMPTY;
                end else if (fill_complete && (fill_half == THIS_HALF)) begin
                    state_reg <= HALF_FULL;
                end else if (fill_start && (fill_half == THIS_HALF)) begin
                    state_reg <= HALF_FILLING;
                end
            end

            assign half_full[gi]  = (state_reg == HALF_FULL);
            assign half_empty[gi] = (state_reg == HALF_EMPTY);
        end
    endgenerate

    always_comb begin
        sel_half = half_full[1];
        if (&half_full) begin
            sel_half = older_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_reg     <= 1'b0;
            pres_half_reg <= HALF_0;
            older_reg     <= HALF_0;
        end else begin
            // Dropping ready for a cycle after each release guarantees the DSP
            // sees a clean edge before the next frame is presented.
            if (ready_reg) begin
                if (frame_done) begin
                    ready_reg <= 1'b0;
                end
            end else if (|half_full) begin
                ready_reg     <= 1'b1;
                pres_half_reg <= sel_half;
            end

            if (fill_complete && (!half_full[~fill_half] || release_valid)) begin
                older_reg <= fill_half;
            end else if (release_valid) begin
                older_reg <= ~pres_half_reg;
            end
        end
    end

    assign frame_ready = ready_reg;
    assign frame_base  = ADDR_W'(half_base(pres_half_reg, ADDR_W));

endmodule

// File: rtl/dsp_sample_loader.sv
// Receiver-sample ingest into bank I: writer FSM, per-half index counter,
// one-cycle write register and overrun accounting around the half tracker.
module dsp_sample_loader
    import dsp_sample_loader_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int FRAME_LEN    = 256,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic [ADDR_W-1:0]       sram_write_addr,
    output logic [DATA_W-1:0]       sram_write_data,
    output logic                    sram_write_en,
    output logic                    frame_ready,
    output logic [ADDR_W-1:0]       frame_base,
    input  logic                    frame_done,
    output logic                    overrun,
    output logic [DROP_COUNT_W-1:0] drop_count
);

    localparam int               IDX_W    = ADDR_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    writer_state_t           state_reg, state_next;
    logic                    cur_half_reg, cur_half_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    active_reg;
    logic                    wr_en_reg;
    logic [ADDR_W-1:0]       wr_addr_reg;
    logic [DATA_W-1:0]       wr_data_reg;
    logic                    overrun_reg;
    logic [DROP_COUNT_W-1:0] drop_count_reg;

    logic       accept;
    logic       drop;
    logic       last_sample;
    logic       other_free;
    logic       fill_start;
    logic       fill_complete;
    logic       release_valid;
    logic       release_half;
    logic [1:0] half_empty;

    // active_reg holds in_ready low for the reset cycle itself.
    assign in_ready      = active_reg & ((state_reg == W_FILL) | (DROP_ON_FULL != 0));
    assign accept        = in_valid & in_ready & (state_reg == W_FILL);
    assign drop          = in_valid & in_ready & (state_reg == W_STALL);
    assign last_sample   = (idx_reg == LAST_IDX);
    assign fill_start    = accept & (idx_reg == '0);
    assign fill_complete = accept & last_sample;
    // A half released in the same cycle counts as free, avoiding a STALL bubble.
    assign other_free    = half_empty[~cur_half_reg]
                         | (release_valid & (release_half != cur_half_reg));

    always_comb begin
        state_next    = state_reg;
        cur_half_next = cur_half_reg;
        idx_next      = idx_reg;
        if (state_reg == W_FILL) begin
            if (accept) begin
                if (last_sample) begin
                    idx_next = '0;
                    if (other_free) begin
                        cur_half_next = ~cur_half_reg;
                    end else begin
                        state_next = W_STALL;
                    end
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
        end else begin
            if (release_valid) begin
                state_next    = W_FILL;
                cur_half_next = release_half;
                idx_next      = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= W_FILL;
            cur_half_reg   <= HALF_0;
            idx_reg        <= '0;
            active_reg     <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            overrun_reg    <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cur_half_reg <= cur_half_next;
            idx_reg      <= idx_next;
            active_reg   <= 1'b1;
            wr_en_reg    <= accept;
            if (accept) begin
                wr_addr_reg <= {cur_half_reg, idx_reg};
                wr_data_reg <= in_data;
            end
            if (drop) begin
                overrun_reg <= 1'b1;
                if (drop_count_reg != '1) begin
                    drop_count_reg <= drop_count_reg + 1'b1;
                end
            end
        end
    end

    dsp_loader_half_tracker #(
        .ADDR_W(ADDR_W)
    ) u_half_tracker (
        .clk          (clk),
        .rst          (rst),
        .fill_start   (fill_start),
        .fill_complete(fill_complete),
        .fill_half    (cur_half_reg),
        .frame_done   (frame_done),
        .half_empty   (half_empty),
        .frame_ready  (frame_ready),
        .frame_base   (frame_base),
        .release_valid(release_valid),
        .release_half (release_half)
    );

    assign sram_write_en   = wr_en_reg;
    assign sram_write_addr = wr_addr_reg;
    assign sram_write_data = wr_data_reg;
    assign overrun         = overrun_reg;
    assign drop_count      = drop_count_reg;

endmodule

// File: tb/tb_dsp_sample_loader.sv
// Randomized bench for dsp_sample_loader: a backpressure instance and a drop
// instance share the stimulus and are compared every cycle to a frame-level model.
module tb_dsp_sample_loader;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 4;
    localparam int FRAME_LEN  = 4;
    localparam int HALF_WORDS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              frame_done;

    logic [1:0]        in_ready;
    logic [1:0]        wr_en;
    logic [1:0]        frame_ready;
    logic [1:0]        overrun;
    logic [ADDR_W-1:0] wr_addr    [2];
    logic [DATA_W-1:0] wr_data    [2];
    logic [ADDR_W-1:0] frame_base [2];
    logic [15:0]       drop_count [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            dsp_sample_loader #(
                .DATA_W      (DATA_W),
                .ADDR_W      (ADDR_W),
                .FRAME_LEN   (FRAME_LEN),
                .DROP_ON_FULL(gi)
            ) u_dut (
                .clk            (clk),
                .rst            (rst),
                .in_valid       (in_valid),
                .in_data        (in_data),
                .in_ready       (in_ready[gi]),
                .sram_write_addr(wr_addr[gi]),
                .sram_write_data(wr_data[gi]),
                .sram_write_en  (wr_en[gi]),
                .frame_ready    (frame_ready[gi]),
                .frame_base     (frame_base[gi]),
                .frame_done     (frame_done),
                .overrun        (overrun[gi]),
                .drop_count     (drop_count[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Model: frames owned by the DSP are kept oldest-first in fq0/fq1.
    int m_act [2], m_stl [2], m_fh [2], m_cnt [2];
    int m_nfull [2], m_fq0 [2], m_fq1 [2];
    int m_rdy [2], m_base [2];
    int m_wen [2], m_waddr [2], m_wdata [2];
    int m_ovr [2], m_drops [2], m_inrst [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit v,
                              input logic [DATA_W-1:0] d, input bit done);
        bit stalled, ir, acc, rel;
        int relh;
        if (r) begin
            m_act[i] = 0; m_stl[i] = 0; m_fh[i] = 0; m_cnt[i] = 0;
            m_nfull[i] = 0; m_fq0[i] = 0; m_fq1[i] = 0;
            m_rdy[i] = 0; m_base[i] = 0;
            m_wen[i] = 0; m_waddr[i] = 0; m_wdata[i] = 0;
            m_ovr[i] = 0; m_drops[i] = 0; m_inrst[i] = 1;
            return;
        end
        m_inrst[i] = 0;
        stalled = (m_stl[i] != 0);
        ir      = (m_act[i] != 0) && (!stalled || i == 1);
        acc     = v && ir;
        rel     = (m_rdy[i] != 0) && done;
        relh    = m_base[i];

        // Presentation decided on ownership as it stood before this edge.
        if (m_rdy[i] != 0) begin
            if (done) m_rdy[i] = 0;
        end else if (m_nfull[i] > 0) begin
            m_rdy[i]  = 1;
            m_base[i] = m_fq0[i];
        end
        if (rel) begin
            m_fq0[i] = m_fq1[i];
            m_nfull[i]--;
        end

        m_wen[i] = (acc && !stalled) ? 1 : 0;
        if (acc && !stalled) begin
            m_waddr[i] = m_fh[i] * HALF_WORDS + m_cnt[i];
            m_wdata[i] = int'(d);
            if (i == 0)
                $display("cycle %0d: accept data=%h -> addr %0d", cycle, d, m_waddr[i]);
        end
        if (acc && stalled) begin
            m_ovr[i] = 1;
            if (m_drops[i] < 65535) m_drops[i]++;
        end

        if (acc && !stalled) begin
            if (m_cnt[i] == FRAME_LEN - 1) begin
                if (m_nfull[i] == 0) m_fq0[i] = m_fh[i];
                else                 m_fq1[i] = m_fh[i];
                m_nfull[i]++;
                m_cnt[i] = 0;
                if (m_nfull[i] == 1) m_fh[i] = 1 - m_fh[i];
                else                 m_stl[i] = 1;
            end else begin
                m_cnt[i]++;
            end
        end else if (stalled && rel) begin
            m_stl[i] = 0;
            m_fh[i]  = relh;
            m_cnt[i] = 0;
        end
        m_act[i] = 1;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("inst%0d in_ready", i), 32'(in_ready[i]),
                  32'((m_act[i] != 0) && (m_stl[i] == 0 || i == 1)));
            check($sformatf("inst%0d sram_write_en", i), 32'(wr_en[i]), 32'(m_wen[i]));
            check($sformatf("inst%0d frame_ready", i), 32'(frame_ready[i]), 32'(m_rdy[i]));
            check($sformatf("inst%0d overrun", i), 32'(overrun[i]), 32'(m_ovr[i]));
            check($sformatf("inst%0d drop_count", i), 32'(drop_count[i]), 32'(m_drops[i]));
            if (m_wen[i] != 0 || m_inrst[i] != 0) begin
                check($sformatf("inst%0d sram_write_addr", i), 32'(wr_addr[i]), 32'(m_waddr[i]));
                check($sformatf("inst%0d sram_write_data", i), 32'(wr_data[i]), 32'(m_wdata[i]));
            end
            if (m_rdy[i] != 0 || m_inrst[i] != 0) begin
                check($sformatf("inst%0d frame_base", i), 32'(frame_base[i]),
                      32'(m_base[i] * HALF_WORDS));
            end
        end
    endtask

    // Phases: cycles, percent valid, percent frame_done, percent reset.
    localparam int NPH = 9;
    int ph_cycles [NPH] = '{3, 20, 1, 10, 200, 40, 300, 3, 8};
    int ph_valid  [NPH] = '{0, 100, 100, 100, 70, 100, 80, 0, 100};
    int ph_done   [NPH] = '{0, 0, 100, 0, 15, 0, 30, 0, 0};
    int ph_rst    [NPH] = '{100, 0, 0, 0, 0, 0, 2, 100, 0};

    initial begin
        bit r, v, dn;
        logic [DATA_W-1:0] d;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        frame_done = 1'b0;
        for (int i = 0; i < 2; i++) model_step(i, 1'b1, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);

        for (int p = 0; p < NPH; p++) begin
            for (int c = 0; c < ph_cycles[p]; c++) begin
                @(negedge clk);
                cycle++;
                check_outputs();
                r  = ($urandom_range(99) < ph_rst[p]);
                v  = ($urandom_range(99) < ph_valid[p]);
                dn = ($urandom_range(99) < ph_done[p]);
                d  = DATA_W'($urandom_range(65535));
                rst        = r;
                in_valid   = v;
                in_data    = d;
                frame_done = dn;
                for (int i = 0; i < 2; i++) model_step(i, r, v, d, dn);
            end
        end
        @(negedge clk);
        cycle++;
        check_outputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
